// File: rtl/unidade_controle_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller side uses the slave modport; the datapath (or bench) uses master.
interface unidade_controle_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pcWrite;
  logic       pcWriteCond;
  logic       iorD;
  logic       memWrite;
  logic       irWrite;
  logic       regWrite;
  logic       seletorMuxUlaA;
  logic [1:0] seletorMuxUlaB;
  logic [2:0] ulaOp;
  logic       seletorMuxRegDst;
  logic       seletorMuxMemToReg;
  logic [1:0] seletorMuxPcSource;
  logic       erroOpcode;
  logic [3:0] estadoAtual;

  modport master (
    output opcode, funct, zero,
    input  pcWrite, pcWriteCond, iorD, memWrite, irWrite, regWrite, seletorMuxUlaA,
    input  seletorMuxUlaB, ulaOp, seletorMuxRegDst, seletorMuxMemToReg, seletorMuxPcSource,
    input  erroOpcode, estadoAtual
  );

  modport slave (
    input  opcode, funct, zero,
    output pcWrite, pcWriteCond, iorD, memWrite, irWrite, regWrite, seletorMuxUlaA,
    output seletorMuxUlaB, ulaOp, seletorMuxRegDst, seletorMuxMemToReg, seletorMuxPcSource,
    output erroOpcode, estadoAtual
  );
endinterface

// File: rtl/unidade_controle.sv
// Moore control unit for a multicycle MIPS subset (R-type, addi, lw, sw, beq, j).
// Outputs decode from the current state only, except ulaOp in EXEC_R which also uses funct.
module unidade_controle (
  input logic                clock,
  input logic                reset,
  unidade_controle_if.slave  bus
);

  typedef enum logic [3:0] {
    StFetch       = 4'd0,
    StFetchEspera = 4'd1,
    StDecode      = 4'd2,
    StExecR       = 4'd3,
    StWbR         = 4'd4,
    StExecI       = 4'd5,
    StWbI         = 4'd6,
    StEndereco    = 4'd7,
    StLwLer       = 4'd8,
    StLwEspera    = 4'd9,
    StLwWb        = 4'd10,
    StSwEscreve   = 4'd11,
    StBeq         = 4'd12,
    StJump        = 4'd13,
    StExcecao     = 4'd14,
    StReset       = 4'd15
  } state_e;

  localparam logic [2:0] UlaNone = 3'b000;
  localparam logic [2:0] UlaAdd  = 3'b001;
  localparam logic [2:0] UlaSub  = 3'b010;
  localparam logic [2:0] UlaAnd  = 3'b011;
  localparam logic [2:0] UlaOr   = 3'b100;
  localparam logic [2:0] UlaSlt  = 3'b111;

  state_e r_state;
  state_e w_next_state;

  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_ior_d;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_ula_a;
  logic [1:0] w_ula_b;
  logic [2:0] w_ula_op;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic [1:0] w_pc_source;
  logic       w_erro;

  // Branch resolution happens in the datapath via pcWriteCond, so zero is not needed here.
  logic w_zero_unused;
  assign w_zero_unused = bus.zero;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StReset;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state    = StReset;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_ior_d         = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_ula_a         = 1'b0;
    w_ula_b         = 2'b00;
    w_ula_op        = UlaNone;
    w_reg_dst       = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_pc_source     = 2'b00;
    w_erro          = 1'b0;

    case (r_state)
      StReset: w_next_state = StFetch;
      StFetch: begin
        w_ula_b      = 2'b01;
        w_ula_op     = UlaAdd;
        w_next_state = StFetchEspera;
      end
      StFetchEspera: begin
        w_ir_write   = 1'b1;
        w_pc_write   = 1'b1;
        w_ula_b      = 2'b01;
        w_ula_op     = UlaAdd;
        w_next_state = StDecode;
      end
      StDecode: begin
        // Branch target is precomputed here while the opcode is being decoded.
        w_ula_b  = 2'b11;
        w_ula_op = UlaAdd;
        case (bus.opcode)
          6'h00:        w_next_state = StExecR;
          6'h08:        w_next_state = StExecI;
          6'h23, 6'h2B: w_next_state = StEndereco;
          6'h04:        w_next_state = StBeq;
          6'h02:        w_next_state = StJump;
          default:      w_next_state = StExcecao;
        endcase
      end
      StExecR: begin
        w_ula_a      = 1'b1;
        w_ula_b      = 2'b00;
        w_next_state = StWbR;
        case (bus.funct)
          6'h20:   w_ula_op = UlaAdd;
          6'h22:   w_ula_op = UlaSub;
          6'h24:   w_ula_op = UlaAnd;
          6'h25:   w_ula_op = UlaOr;
          6'h2A:   w_ula_op = UlaSlt;
          default: w_next_state = StExcecao;
        endcase
      end
      StWbR: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_next_state = StFetch;
      end
      StExecI: begin
        w_ula_a      = 1'b1;
        w_ula_b      = 2'b10;
        w_ula_op     = UlaAdd;
        w_next_state = StWbI;
      end
      StWbI: begin
        w_reg_write  = 1'b1;
        w_next_state = StFetch;
      end
      StEndereco: begin
        w_ula_a  = 1'b1;
        w_ula_b  = 2'b10;
        w_ula_op = UlaAdd;
        // Opcode is re-checked in case the instruction register changed unexpectedly.
        case (bus.opcode)
          6'h23:   w_next_state = StLwLer;
          6'h2B:   w_next_state = StSwEscreve;
          default: w_next_state = StExcecao;
        endcase
      end
      StLwLer: begin
        w_ior_d      = 1'b1;
        w_next_state = StLwEspera;
      end
      StLwEspera: begin
        w_ior_d      = 1'b1;
        w_next_state = StLwWb;
      end
      StLwWb: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next_state = StFetch;
      end
      StSwEscreve: begin
        w_ior_d      = 1'b1;
        w_mem_write  = 1'b1;
        w_next_state = StFetch;
      end
      StBeq: begin
        w_ula_a         = 1'b1;
        w_ula_op        = UlaSub;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
        w_next_state    = StFetch;
      end
      StJump: begin
        w_pc_write   = 1'b1;
        w_pc_source  = 2'b10;
        w_next_state = StFetch;
      end
      StExcecao: begin
        w_erro       = 1'b1;
        w_next_state = StExcecao;
      end
      default: w_next_state = StReset;
    endcase
  end

  assign bus.pcWrite            = w_pc_write;
  assign bus.pcWriteCond        = w_pc_write_cond;
  assign bus.iorD               = w_ior_d;
  assign bus.memWrite           = w_mem_write;
  assign bus.irWrite            = w_ir_write;
  assign bus.regWrite           = w_reg_write;
  assign bus.seletorMuxUlaA     = w_ula_a;
  assign bus.seletorMuxUlaB     = w_ula_b;
  assign bus.ulaOp              = w_ula_op;
  assign bus.seletorMuxRegDst   = w_reg_dst;
  assign bus.seletorMuxMemToReg = w_mem_to_reg;
  assign bus.seletorMuxPcSource = w_pc_source;
  assign bus.erroOpcode         = w_erro;
  assign bus.estadoAtual        = r_state;

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: directed scenarios plus randomized instruction
// streams checked against an instruction-level model of the state walk and control outputs.
module tb_unidade_controle;

  logic clock = 1'b0;
  logic reset = 1'b1;

  unidade_controle_if bus ();

  unidade_controle dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  // {pcWrite, pcWriteCond, iorD, memWrite, irWrite, regWrite, ulaA, ulaB, ulaOp,
  //  regDst, memToReg, pcSource, erroOpcode}
  logic [16:0] obs;
  assign obs = {bus.pcWrite, bus.pcWriteCond, bus.iorD, bus.memWrite, bus.irWrite,
                bus.regWrite, bus.seletorMuxUlaA, bus.seletorMuxUlaB, bus.ulaOp,
                bus.seletorMuxRegDst, bus.seletorMuxMemToReg, bus.seletorMuxPcSource,
                bus.erroOpcode};

  function automatic logic [2:0] alu_for(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'd1;
      6'h22:   return 3'd2;
      6'h24:   return 3'd3;
      6'h25:   return 3'd4;
      6'h2A:   return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [16:0] exp_out(input int st, input logic [5:0] fn);
    logic pw, pwc, iord, mw, irw, rw, ua, rd, m2r, err;
    logic [1:0] ub, ps;
    logic [2:0] op;
    {pw, pwc, iord, mw, irw, rw, ua, rd, m2r, err} = '0;
    ub = 2'd0; ps = 2'd0; op = 3'd0;
    case (st)
      0:    begin ub = 2'd1; op = 3'd1; end
      1:    begin irw = 1; pw = 1; ub = 2'd1; op = 3'd1; end
      2:    begin ub = 2'd3; op = 3'd1; end
      3:    begin ua = 1; op = alu_for(fn); end
      4:    begin rw = 1; rd = 1; end
      5, 7: begin ua = 1; ub = 2'd2; op = 3'd1; end
      6:    rw = 1;
      8, 9: iord = 1;
      10:   begin rw = 1; m2r = 1; end
      11:   begin iord = 1; mw = 1; end
      12:   begin ua = 1; op = 3'd2; pwc = 1; ps = 2'd1; end
      13:   begin pw = 1; ps = 2'd2; end
      14:   err = 1;
      default: ;
    endcase
    return {pw, pwc, iord, mw, irw, rw, ua, ub, op, rd, m2r, ps, err};
  endfunction

  // Returns 1 when the instruction ends in the trap state.
  function automatic bit build_seq(input logic [5:0] op, input logic [5:0] fn);
    bit trap;
    trap = 0;
    exp_q = {0, 1, 2};
    case (op)
      6'h00: begin
        exp_q.push_back(3);
        if (alu_for(fn) != 3'd0 || fn == 6'h20) exp_q.push_back(4);
        else trap = 1;
      end
      6'h08: begin exp_q.push_back(5); exp_q.push_back(6); end
      6'h23: begin exp_q.push_back(7); exp_q.push_back(8); exp_q.push_back(9);
                   exp_q.push_back(10); end
      6'h2B: begin exp_q.push_back(7); exp_q.push_back(11); end
      6'h04: exp_q.push_back(12);
      6'h02: exp_q.push_back(13);
      default: trap = 1;
    endcase
    // Trap entry plus ten cycles of holding.
    if (trap) for (int k = 0; k < 11; k++) exp_q.push_back(14);
    return trap;
  endfunction

  // Entered at a falling edge with the DUT in FETCH; leaves it the same way.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input string name);
    bit trap;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = z;
    trap = build_seq(op, fn);
    foreach (exp_q[i]) begin
      total++;
      if (bus.estadoAtual !== 4'(exp_q[i])) begin
        bad++;
        $display("FAIL %s state step %0d: got %0d want %0d", name, i, bus.estadoAtual,
                 exp_q[i]);
      end
      total++;
      if (obs !== exp_out(exp_q[i], fn)) begin
        bad++;
        $display("FAIL %s outputs step %0d (state %0d): got %b want %b", name, i, exp_q[i],
                 obs, exp_out(exp_q[i], fn));
      end
      @(posedge clock);
      @(negedge clock);
    end
    if (trap) begin
      #1 reset = 1'b1;
      #1;
      total++;
      if (bus.estadoAtual !== 4'd15 || obs !== 17'd0) begin
        bad++;
        $display("FAIL %s trap recovery: got state %0d outs %b want 15 / 0", name,
                 bus.estadoAtual, obs);
      end
      #1 reset = 1'b0;
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if (bus.estadoAtual !== 4'd15) begin
      bad++;
      $display("FAIL reset_state: got %0d want 15", bus.estadoAtual);
    end
    total++;
    if (obs !== 17'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0", obs);
    end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    total++;
    if (bus.estadoAtual !== 4'd0) begin
      bad++;
      $display("FAIL reset_release: got %0d want 0", bus.estadoAtual);
    end
  endtask

  task automatic test_reset_mid_sw();
    bus.opcode = 6'h2B;
    bus.funct  = 6'h00;
    bus.zero   = 1'b0;
    repeat (4) begin
      @(posedge clock);
      @(negedge clock);
    end
    total++;
    if (bus.estadoAtual !== 4'd11 || bus.memWrite !== 1'b1) begin
      bad++;
      $display("FAIL mid_sw_entry: got state %0d memWrite %b want 11 / 1", bus.estadoAtual,
               bus.memWrite);
    end
    #1 reset = 1'b1;
    #1;
    total++;
    if (bus.estadoAtual !== 4'd15 || bus.memWrite !== 1'b0) begin
      bad++;
      $display("FAIL mid_sw_async: got state %0d memWrite %b want 15 / 0", bus.estadoAtual,
               bus.memWrite);
    end
    #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    total++;
    if (bus.estadoAtual !== 4'd0 || bus.memWrite !== 1'b0 || bus.regWrite !== 1'b0) begin
      bad++;
      $display("FAIL mid_sw_refetch: got state %0d memWrite %b regWrite %b want 0 / 0 / 0",
               bus.estadoAtual, bus.memWrite, bus.regWrite);
    end
  endtask

  task automatic test_random(input int n);
    logic [5:0] ops[6];
    logic [5:0] fns[5];
    logic [5:0] op, fn;
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int i = 0; i < n; i++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 9))
        8:       op = 6'h00;
        9:       op = 6'($urandom);
        default: begin
          op = ops[$urandom_range(0, 5)];
          fn = fns[$urandom_range(0, 4)];
        end
      endcase
      run_instr(op, fn, 1'($urandom), "random");
    end
  endtask

  initial begin
    bus.opcode = 6'h00;
    bus.funct  = 6'h00;
    bus.zero   = 1'b0;
    test_reset();
    run_instr(6'h00, 6'h22, 1'b0, "r_sub");
    run_instr(6'h23, 6'h00, 1'b0, "lw");
    run_instr(6'h04, 6'h00, 1'b1, "beq");
    run_instr(6'h3F, 6'h00, 1'b0, "illegal_opcode");
    run_instr(6'h00, 6'h3F, 1'b0, "illegal_funct");
    test_reset_mid_sw();
    run_instr(6'h02, 6'h00, 1'b0, "jump");
    run_instr(6'h08, 6'h00, 1'b0, "addi");
    test_random(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule
